// File: rtl/usb_pkg.sv
// Shared USB line-level definitions: line-state encodings, packet bit limits
// and the transmit line-driver state enum.
package usb_pkg;

    localparam logic [1:0] LINE_J = 2'b10;
    localparam logic [1:0] LINE_K = 2'b01;
    localparam logic [1:0] LINE_X = 2'b00;

    localparam logic [6:0] DATA_BITS   = 7'd101;
    localparam logic [6:0] HSHAKE_BITS = 7'd8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_DATA,
        TX_EOP1,
        TX_EOP2,
        TX_EOPJ
    } tx_state_e;

    // SYNC pattern KJKJKJKK: odd symbols are J except the closing K.
    function automatic logic [1:0] sync_symbol(input logic [2:0] idx);
        return (idx[0] && (idx != 3'd7)) ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mux2to1.sv
// Two-input multiplexer: y = sel ? b : a.
module mux2to1 #(
    parameter int W = 7
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/register.sv
// Load-enable register with synchronous clear (priority).
module register #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tx_dpdm.sv
// Transmit-side USB D+/D- line driver: SYNC, NRZI bits as J/K, EOP (SE0,SE0,J),
// then bus release. Line state and bus enable are registered.
module tx_dpdm
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_data,
    input  logic       send_hshake,
    input  logic       abort,
    input  logic       s_in,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       bit_req,
    output logic [1:0] bus_out,
    output logic       bus_en,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output tx_state_e  dbg_state_o
);

    tx_state_e  state_q, state_d;
    logic [2:0] sync_q, sync_d;
    logic [1:0] bus_q, bus_d;
    logic       en_q, en_d;
    logic       done_q, done_d;

    logic       start;
    logic       take;
    logic       consume;
    logic       is_hshake;
    logic       load_limit;
    logic [6:0] bit_cnt;
    logic [6:0] cnt_inc;
    logic [6:0] limit_mux;
    logic [6:0] limit_q;
    logic       req_c;
    logic       err_c;

    assign start      = send_hshake | send_data;
    assign load_limit = (state_q == TX_IDLE) && start && !abort;
    assign is_hshake  = (limit_q == HSHAKE_BITS);
    assign cnt_inc    = bit_cnt + 7'd1;

    // The bit pull starts on the last SYNC cycle so the first data bit follows
    // the closing K without a gap.
    assign take    = (state_q == TX_DATA) || ((state_q == TX_SYNC) && (sync_q == 3'd7));
    assign consume = take && s_valid && !abort;

    mux2to1 #(.W(7)) u_limit_mux (
        .sel_i (send_hshake),
        .a_i   (DATA_BITS),
        .b_i   (HSHAKE_BITS),
        .y_o   (limit_mux)
    );

    register #(.W(7)) u_limit_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (abort),
        .en_i  (load_limit),
        .d_i   (limit_mux),
        .q_o   (limit_q)
    );

    counter #(.W(7)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (abort || (state_q == TX_IDLE)),
        .en_i  (consume),
        .cnt_o (bit_cnt)
    );

    // Bit handshake: bit_req is the ready; a bit transfers in any cycle where
    // both bit_req and s_valid are high. Dropping s_valid while bit_req is high
    // is an underrun and ends the packet.
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        bus_d   = bus_q;
        en_d    = en_q;
        done_d  = 1'b0;
        req_c   = 1'b0;
        err_c   = 1'b0;

        case (state_q)
            TX_IDLE: begin
                bus_d  = LINE_J;
                en_d   = 1'b0;
                sync_d = 3'd0;
                if (start) begin
                    state_d = TX_SYNC;
                    bus_d   = sync_symbol(3'd0);
                    en_d    = 1'b1;
                end
            end
            TX_SYNC: begin
                if (sync_q != 3'd7) begin
                    sync_d = sync_q + 3'd1;
                    bus_d  = sync_symbol(sync_q + 3'd1);
                end
            end
            TX_DATA: begin
            end
            TX_EOP1: begin
                bus_d   = LINE_X;
                state_d = TX_EOP2;
            end
            TX_EOP2: begin
                bus_d   = LINE_X;
                state_d = TX_EOPJ;
            end
            TX_EOPJ: begin
                bus_d   = LINE_J;
                done_d  = 1'b1;
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (take) begin
            req_c = 1'b1;
            if (s_valid) begin
                bus_d   = s_in ? LINE_J : LINE_K;
                state_d = TX_DATA;
                if (s_last) begin
                    state_d = TX_EOP1;
                    err_c   = is_hshake && (cnt_inc != HSHAKE_BITS);
                end else if (cnt_inc == limit_q) begin
                    state_d = TX_EOP1;
                    err_c   = 1'b1;
                end
            end else begin
                // Underrun: the first SE0 goes out immediately, so skip EOP1.
                bus_d   = LINE_X;
                err_c   = 1'b1;
                state_d = TX_EOP2;
            end
        end

        if (abort) begin
            state_d = TX_IDLE;
            sync_d  = 3'd0;
            bus_d   = LINE_J;
            en_d    = 1'b0;
            done_d  = 1'b0;
            req_c   = 1'b0;
            err_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            sync_q  <= 3'd0;
            bus_q   <= LINE_J;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign bit_req     = req_c;
    assign tx_error    = err_c;
    assign bus_out     = bus_q;
    assign bus_en      = en_q;
    assign tx_done     = done_q;
    assign tx_busy     = (state_q != TX_IDLE);
    assign dbg_state_o = state_q;

endmodule
